// File: rtl/jump_pkg.sv
// Shared types and defaults for the jump game controller.
// No logic; consumed by jump_ctrl.
// Positions are 10-bit unsigned screen coordinates.
package jump_pkg;

    localparam int MAN_HOME_DEF = 60;
    localparam int STAGE_W_DEF  = 40;
    localparam int SCREEN_W_DEF = 640;
    localparam int FIX_GAP_DEF  = 120;
    localparam int POS_W        = 10;
    localparam int STAGE1_HOME  = 200;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHARGE,
        ST_JUMP,
        ST_LAND,
        ST_SCROLL,
        ST_OVER
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gap_lfsr.sv
// Gap randomiser: 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, seed 8'hA5.
// Latency: new value one clk after an adv cycle.
// Backpressure: none; advances whenever adv is high.
module gap_lfsr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    output logic [5:0] rnd
);

    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else if (adv) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign rnd = lfsr[5:0];

endmodule

// File: rtl/jump_ctrl.sv
// Jump game controller: charge while btn held, jump, land/score, hand off to scroll block.
// Latency: motion advances one px per pulse; move_en is registered (rises the cycle after LAND).
// Backpressure: SCROLL waits indefinitely on move_fin. Option: JUMP_RAND_GAP_EN (random stage gap).
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int MAN_HOME = MAN_HOME_DEF,
    parameter int STAGE_W  = STAGE_W_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int FIX_GAP  = FIX_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pulse,
    input  logic       btn,
    input  logic       move_fin,
    input  logic [9:0] new_man_x,
    input  logic [9:0] new_stage_x [0:1],
    output logic       move_en,
    output logic [9:0] man_x,
    output logic [9:0] stage_x [0:1],
    output logic [7:0] charge,
    output logic [7:0] score,
    output logic       game_over
);

    localparam pos_t        HOME_X    = pos_t'(MAN_HOME);
    localparam pos_t        HOME_S0   = pos_t'(MAN_HOME - STAGE_W / 2);
    localparam pos_t        HOME_S1   = pos_t'(STAGE1_HOME);
    localparam pos_t        MAN_MAX   = pos_t'(SCREEN_W - 1);
    localparam logic [10:0] STAGE_EXT = 11'(STAGE_W - 1);
    localparam logic [10:0] S1_MAX    = 11'(SCREEN_W - STAGE_W);

    state_t     state, state_nxt;
    pos_t       man_r, s0_r, s1_r;
    logic [7:0] charge_r, remain_r, score_r;
    logic       move_en_r, btn_q;
    pos_t       gap;

`ifdef JUMP_RAND_GAP_EN
    logic [5:0] gap_rnd;

    gap_lfsr u_gap_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (pulse),
        .rnd   (gap_rnd)
    );

    assign gap = pos_t'(80) + pos_t'(gap_rnd);
`else
    assign gap = pos_t'(FIX_GAP);
`endif

    logic        jump_done, on_target, on_home, btn_rise;
    logic [10:0] s1_end, s0_end, s1_sum;
    pos_t        s1_next;

    assign jump_done = (remain_r == 8'd0) || (man_r == MAN_MAX);
    assign s1_end    = {1'b0, s1_r} + STAGE_EXT;
    assign s0_end    = {1'b0, s0_r} + STAGE_EXT;
    assign on_target = (man_r >= s1_r) && ({1'b0, man_r} <= s1_end);
    assign on_home   = (man_r >= s0_r) && ({1'b0, man_r} <= s0_end);
    assign btn_rise  = btn && !btn_q;

    // Next target edge: sum in 11 bits so the clamp sees true overflow.
    assign s1_sum  = {1'b0, new_stage_x[1]} + {1'b0, gap};
    assign s1_next = (s1_sum > S1_MAX) ? pos_t'(S1_MAX) : s1_sum[9:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (btn)       state_nxt = ST_CHARGE;
            ST_CHARGE: if (!btn)      state_nxt = ST_JUMP;
            ST_JUMP:   if (jump_done) state_nxt = ST_LAND;
            ST_LAND: begin
                if (on_target)        state_nxt = ST_SCROLL;
                else if (on_home)     state_nxt = ST_IDLE;
                else                  state_nxt = ST_OVER;
            end
            ST_SCROLL: if (move_fin)  state_nxt = ST_IDLE;
            ST_OVER:   if (btn_rise)  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            man_r     <= HOME_X;
            s0_r      <= HOME_S0;
            s1_r      <= HOME_S1;
            charge_r  <= 8'd0;
            remain_r  <= 8'd0;
            score_r   <= 8'd0;
            move_en_r <= 1'b0;
            btn_q     <= 1'b0;
        end else begin
            btn_q     <= btn;
            move_en_r <= (state_nxt == ST_SCROLL);
            unique case (state)
                ST_IDLE: if (btn) charge_r <= 8'd0;
                ST_CHARGE: begin
                    // A pulse coinciding with release still counts toward the jump.
                    if (pulse) charge_r <= sat_inc8(charge_r);
                    if (!btn)  remain_r <= pulse ? sat_inc8(charge_r) : charge_r;
                end
                ST_JUMP: begin
                    if (pulse && !jump_done) begin
                        man_r    <= man_r + pos_t'(1);
                        remain_r <= remain_r - 8'd1;
                    end
                end
                ST_LAND: if (on_target) score_r <= sat_inc8(score_r);
                ST_SCROLL: begin
                    if (move_fin) begin
                        man_r <= new_man_x;
                        s0_r  <= new_stage_x[1];
                        s1_r  <= s1_next;
                    end
                end
                ST_OVER: begin
                    if (btn_rise) begin
                        man_r   <= HOME_X;
                        s0_r    <= HOME_S0;
                        s1_r    <= HOME_S1;
                        score_r <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // While scrolling, positions come straight from the scroll block.
    always_comb begin
        man_x      = man_r;
        stage_x[0] = s0_r;
        stage_x[1] = s1_r;
        if (state == ST_SCROLL) begin
            man_x      = new_man_x;
            stage_x[0] = new_stage_x[0];
            stage_x[1] = new_stage_x[1];
        end
        game_over = (state == ST_OVER);
        move_en   = move_en_r;
        charge    = charge_r;
        score     = score_r;
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: directed scenarios then randomized jumps
// against a position/score model; also acts as the scroll block.
module tb_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pulse = 1'b0;
    logic       btn = 1'b0;
    logic       move_fin = 1'b0;
    logic [9:0] new_man_x = 10'd0;
    logic [9:0] new_stage_x [0:1];
    logic       move_en;
    logic [9:0] man_x;
    logic [9:0] stage_x [0:1];
    logic [7:0] charge;
    logic [7:0] score;
    logic       game_over;

    jump_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pulse       (pulse),
        .btn         (btn),
        .move_fin    (move_fin),
        .new_man_x   (new_man_x),
        .new_stage_x (new_stage_x),
        .move_en     (move_en),
        .man_x       (man_x),
        .stage_x     (stage_x),
        .charge      (charge),
        .score       (score),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Game model: man position, current/target stage left edges, score.
    int m_man, m_s0, m_s1, m_score;
    bit m_over;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic model_home();
        m_man = 60; m_s0 = 40; m_s1 = 200; m_score = 0; m_over = 0;
    endtask

    task automatic check_pos(input string tag);
        check({tag, ".man_x"}, man_x, m_man);
        check({tag, ".stage0"}, stage_x[0], m_s0);
        check({tag, ".stage1"}, stage_x[1], m_s1);
        check({tag, ".score"}, score, m_score);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        btn = 1'b0; pulse = 1'b0; move_fin = 1'b0;
        rst_n = 1'b0;
        #1;
        model_home();
        check_pos("rst");
        check("rst.charge", charge, 0);
        check("rst.move_en", move_en, 0);
        check("rst.game_over", game_over, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Charge for n pulses (last pulse together with release), then jump.
    // hold re-presses btn for the flight; abort pulls reset mid-scroll.
    task automatic do_jump(input int n, input bit hold, input bit abort);
        int  c, land, got, shift, s0v;
        bit  saw_en;
        btn = 1'b1; pulse = 1'b0;
        cyc();
        got = 0;
        while (got < n) begin
            pulse = ($urandom_range(0, 2) != 0);
            if (pulse && got + 1 == n) btn = 1'b0;
            cyc();
            if (pulse) got++;
        end
        pulse = 1'b0;
        c = (n > 255) ? 255 : n;
        check("charge", charge, c);

        land = m_man + ((c < 639 - m_man) ? c : 639 - m_man);
        btn = hold;
        got = 0;
        saw_en = 0;
        while (got < c) begin
            pulse = ($urandom_range(0, 3) != 0);
            cyc();
            if (pulse) got++;
            saw_en |= move_en;
        end
        pulse = 1'b0;
        cyc();
        saw_en |= move_en;
        cyc();

        if (land >= m_s1 && land <= m_s1 + 39) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            check("scroll.move_en", move_en, 1);
            check("scroll.game_over", game_over, 0);
            check("scroll.score", score, m_score);
            new_man_x = 10'(land);
            new_stage_x[0] = 10'(m_s0);
            new_stage_x[1] = 10'(m_s1);
            #1;
            check("scroll.mirror_land", man_x, land);
            if (abort) begin
                #1;
                rst_n = 1'b0;
                #1;
                model_home();
                check("abort.move_en", move_en, 0);
                check_pos("abort");
                check("abort.charge", charge, 0);
                check("abort.game_over", game_over, 0);
                cyc();
                rst_n = 1'b1;
                return;
            end
            cyc();
            check("scroll.hold", move_en, 1);
            shift = m_s1 - 50;
            s0v = m_s0 - shift;
            if (s0v < 0) s0v = 0;
            new_man_x = 10'(land - shift);
            new_stage_x[0] = 10'(s0v);
            new_stage_x[1] = 10'd50;
            #1;
            check("scroll.mirror_man", man_x, land - shift);
            check("scroll.mirror_s1", stage_x[1], 50);
            move_fin = 1'b1;
            cyc();
            move_fin = 1'b0;
            m_man = land - shift;
            m_s0 = 50;
            m_s1 = (50 + 120 > 600) ? 600 : 50 + 120;
            check("scrolled.move_en", move_en, 0);
            check_pos("scrolled");
        end else if (land >= m_s0 && land <= m_s0 + 39) begin
            m_man = land;
            check("home.move_en_seen", saw_en, 0);
            check("home.move_en", move_en, 0);
            check("home.game_over", game_over, 0);
            check_pos("home");
        end else begin
            m_man = land;
            m_over = 1;
            check("over.game_over", game_over, 1);
            check("over.move_en", move_en, 0);
            check_pos("over");
        end
    endtask

    task automatic recover();
        btn = 1'b0;
        cyc();
        check("recover.still_over", game_over, 1);
        btn = 1'b1;
        cyc();
        btn = 1'b0;
        cyc();
        model_home();
        check("recover.game_over", game_over, 0);
        check_pos("recover");
    endtask

    initial begin
        #900000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int n, sel, lo;
        new_stage_x[0] = 10'd0;
        new_stage_x[1] = 10'd0;

        apply_reset();

        // 150 pulses: land on the target stage and scroll to {50,170}.
        do_jump(150, 0, 0);
        check("d150.stage0", stage_x[0], 50);
        check("d150.stage1", stage_x[1], 170);
        check("d150.score", score, 1);

        // Short hop stays on the home stage.
        apply_reset();
        do_jump(10, 0, 0);
        check("d10.man_x", man_x, 70);

        // Overshoot with button held through the flight: release needed first.
        apply_reset();
        do_jump(250, 1, 0);
        check("d250.man_x", man_x, 310);
        cyc(); cyc(); cyc();
        check("d250.held_over", game_over, 1);
        recover();

        // Saturated charge.
        apply_reset();
        do_jump(300, 0, 0);
        check("d300.man_x", man_x, 315);
        recover();

        // Reset while scrolling.
        apply_reset();
        do_jump(150, 0, 1);

        // Randomized jumps, biased toward the stage edges.
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: n = $urandom_range(1, 300);
                1: n = (m_s1 - m_man) + $urandom_range(0, 39);
                2: n = ($urandom_range(0, 1) != 0) ? (m_s1 - m_man - 1) : (m_s1 - m_man + 40);
                default: begin
                    lo = m_s0 + 39 - m_man;
                    n = (lo >= 1) ? $urandom_range(1, lo) : 1;
                end
            endcase
            if (n < 1) n = 1;
            do_jump(n, 0, 0);
            if (m_over) recover();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jump_ctrl.md
JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
REQ-001 Parameters SHALL be: MAN_HOME, 60, man rest x; STAGE_W, 40, stage width px; SCREEN_W, 640, screen width px; FIX_GAP, 120, fixed stage spacing px.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. Ports: clk input 1, clock; rst_n input 1, async active-low reset.
REQ-003 pulse  input  1  step tick; all motion and charge updates occur only on cycles with pulse=1.
REQ-004 btn  input  1  jump button, high while held.
REQ-005 move_fin  input  1  scroll-done flag from the scroll block.
REQ-006 new_man_x  input  10  scrolled man x from the scroll block.
REQ-007 new_stage_x[0:1]  input  2x10  scrolled stage left edges from the scroll block.
REQ-008 move_en  output  1  scroll-block enable; scroll block loads man_x/stage_x while low.
REQ-009 man_x  output  10  man x position.
REQ-010 stage_x[0:1]  output  2x10  left edges of current [0] and target [1] stage.
REQ-011 charge  output  8  current jump charge.
REQ-012 score  output  8  landed-jump count.
REQ-013 game_over  output  1  high in OVER state.

Function
REQ-014 The FSM SHALL have the states IDLE, CHARGE, JUMP, LAND, SCROLL and OVER.
REQ-015 IDLE: btn=1 SHALL go to CHARGE with charge cleared to 0.
REQ-016 CHARGE: each pulse SHALL add 1 to charge, saturating at 255; btn=0 SHALL go to JUMP with remain=charge; a pulse in the same cycle as btn falling SHALL be counted first.
REQ-017 JUMP: each pulse SHALL add 1 to man_x and subtract 1 from remain; remain=0 or man_x=SCREEN_W-1 SHALL go to LAND, and man_x SHALL never exceed SCREEN_W-1.
REQ-018 LAND (1 cycle): stage_x[1] <= man_x <= stage_x[1]+STAGE_W-1 SHALL add 1 to score (saturating at 255) and go to SCROLL; else man_x within stage [0] SHALL go to IDLE with no score change; else SHALL go to OVER.
REQ-019 move_en SHALL be 1 only in SCROLL and SHALL be registered (rises the cycle after LAND).
REQ-020 SCROLL: man_x/stage_x outputs SHALL mirror new_man_x/new_stage_x.
REQ-021 SCROLL: on move_fin=1, SHALL latch man_x<=new_man_x, stage_x[0]<=new_stage_x[1], stage_x[1]<=min(new_stage_x[1]+gap, SCREEN_W-STAGE_W), then go to IDLE with move_en=0.
REQ-022 OVER: game_over=1; a btn rising edge (registered btn_q=0, btn=1) SHALL restore reset positions, clear score and go to IDLE; a btn held on entry SHALL need a release first.
REQ-023 All position arithmetic SHALL be 10-bit unsigned, with the sum computed in 11 bits before the clamp.

Reset
REQ-024 With rst_n=0 the outputs SHALL immediately be: man_x=MAN_HOME, stage_x[0]=MAN_HOME-STAGE_W/2 (40), stage_x[1]=200, charge=0, score=0, move_en=0, game_over=0, state=IDLE, btn_q=0.
REQ-025 Reset in any state, including SCROLL, SHALL drop move_en asynchronously.

Configuration
REQ-026 With JUMP_RAND_GAP_EN defined, gap SHALL be 80+lfsr[5:0] (range 80..143), using an 8-bit LFSR x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset and advanced on every pulse.
REQ-027 Without JUMP_RAND_GAP_EN, gap SHALL be FIX_GAP and no LFSR logic SHALL exist.

Structure
REQ-028 The state enum, the MAN_HOME/STAGE_W/SCREEN_W defaults and the 10-bit position type SHALL reside in shared package jump_pkg.
REQ-029 The LFSR SHALL be sub-module gap_lfsr, instantiated only under JUMP_RAND_GAP_EN.

Verification
REQ-030 Reset -> man_x=60, stage_x={40,200}, score=0, move_en=0.
REQ-031 btn held for 150 pulses then released -> man_x=210, score=1, move_en=1; model scroll returns new_man_x=60, new_stage_x[1]=50 with move_fin -> stage_x={50,170} (fixed gap), state IDLE.
REQ-032 Charge 10 -> man_x=70, IDLE, score unchanged, move_en never 1.
REQ-033 Charge 250 -> man_x=310, game_over=1; release then press -> reset positions, score=0.
REQ-034 btn held for 300 pulses -> charge=255 saturated; jump ends at man_x=315.
REQ-035 rst_n pulled low mid-SCROLL -> move_en=0 and reset values are present before the next clk edge.
